instr_fetch_unit: RTL

- Front end of the R/I/J single-issue CPU: owns the PC, fetches instruction words from instruction memory over a req/ack handshake, and holds each word in an instruction register.
- Presents opa/func to the control decoder and takes back the decoder's 2-bit pcs next-PC select, plus branch/jump fields, when execution of the held instruction completes.
- Also keeps a retired-instruction counter for debug and test.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/next_pc_calc.sv | 27 ++
 rtl/instr_fetch_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: next-PC select codes, fetch FSM states, instruction field positions.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] PCS_SEQ  = 2'b00;
    localparam logic [1:0] PCS_RSEQ = 2'b01;
    localparam logic [1:0] PCS_BR   = 2'b10;
    localparam logic [1:0] PCS_J    = 2'b11;

    localparam int unsigned OPA_HI    = 31;
    localparam int unsigned OPA_LO    = 26;
    localparam int unsigned FUNC_HI   = 5;
    localparam int unsigned FUNC_LO   = 0;
    localparam int unsigned IMM_HI    = 15;
    localparam int unsigned IMM_LO    = 0;
    localparam int unsigned TARGET_HI = 25;
    localparam int unsigned TARGET_LO = 0;

    // S_IDLE is the single post-reset cycle before the first fetch request.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALTED
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, or region-local jump.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    input  logic [1:0]      pcs,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] seq;
    logic [XLEN-1:0] br_off;

    assign seq    = pc + 32'd4;
    assign br_off = {{14{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO], 2'b00};

    always_comb begin
        next_pc = seq;
        case (pcs)
            PCS_SEQ, PCS_RSEQ: next_pc = seq;
            PCS_BR:            next_pc = seq + br_off;
            PCS_J:             next_pc = {seq[31:28], instr[TARGET_HI:TARGET_LO], 2'b00};
            default:           next_pc = seq;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// CPU front end: owns the PC, fetches over a req/ack handshake, holds the instruction
// until execution retires it, and counts retired instructions.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic [5:0]          opa,
    output logic [5:0]          func,
    output logic                instr_valid,
    input  logic                exec_done,
    input  logic [1:0]          pcs,
    input  logic                halt,
    output logic [31:0]         pc,
    output logic [RETIRE_W-1:0] retired
);

    fetch_state_e        state;
    fetch_state_e        state_nxt;
    logic [31:0]         pc_nxt;
    logic [31:0]         instr_nxt;
    logic [RETIRE_W-1:0] retired_nxt;
    logic [31:0]         next_pc;

    next_pc_calc u_next_pc (
        .pc      (pc),
        .instr   (instr),
        .pcs     (pcs),
        .next_pc (next_pc)
    );

    assign opa  = instr[OPA_HI:OPA_LO];
    assign func = instr[FUNC_HI:FUNC_LO];

    // Next-state and datapath update; exec_done only matters while a word is issued.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instr_nxt   = instr;
        retired_nxt = retired;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH, S_WAIT: begin
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_ISSUE: begin
                if (exec_done) begin
                    pc_nxt      = next_pc;
                    retired_nxt = retired + RETIRE_W'(1);
                    state_nxt   = halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            retired     <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            retired     <= retired_nxt;
            imem_req    <= (state_nxt == S_FETCH) || (state_nxt == S_WAIT);
            imem_addr   <= pc_nxt;
            instr_valid <= (state_nxt == S_ISSUE);
        end
    end

endmodule
